// File: rtl/byte_lane_pkg.sv
// Shared types for the byte lane packer: lane byte type, buffer states and lane limit.
package byte_lane_pkg;

    localparam int unsigned MAX_LANES = 8;

    typedef logic [7:0] lane_t;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL
    } buf_state_e;

endpackage

// File: rtl/byte_lane_packer.sv
// Packs a byte stream into LANES-byte words through two ping-pong word buffers.
// Optional macro BYTE_LANE_SWAP_EN presents lane 0 in the MSB byte of out_data.
module byte_lane_packer
    import byte_lane_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*8-1:0] out_data,
    output logic [LANES-1:0]   out_keep,
    output logic               out_last
);

    localparam int unsigned CW = $clog2(LANES);

    logic [1:0][LANES*8-1:0] r_data;
    logic [1:0][LANES-1:0]   r_keep;
    logic [1:0]              r_last;
    buf_state_e              r_state [2];
    logic                    r_wr_sel;
    logic                    r_rd_sel;
    logic [CW-1:0]           r_cnt;

    logic                    w_accept;
    logic                    w_drain;
    logic                    w_close;
    lane_t                   w_byte;
    logic [LANES*8-1:0]      w_rd_data;
    logic [LANES-1:0]        w_rd_keep;

    // in_ready looks only at registered state, so a drain frees space one cycle later
    assign in_ready  = (r_state[r_wr_sel] != FULL);
    assign out_valid = (r_state[r_rd_sel] == FULL);
    assign w_accept  = in_valid && in_ready;
    assign w_drain   = out_valid && out_ready;
    assign w_close   = (r_cnt == CW'(LANES - 1)) || in_last;
    assign w_byte    = in_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data   <= '0;
            r_keep   <= '0;
            r_last   <= '0;
            r_wr_sel <= 1'b0;
            r_rd_sel <= 1'b0;
            r_cnt    <= '0;
            for (int unsigned b = 0; b < 2; b++) begin
                r_state[b] <= EMPTY;
            end
        end else begin
            // A buffer is never written while FULL nor drained unless FULL,
            // so write and drain of the same buffer cannot coincide.
            for (int unsigned b = 0; b < 2; b++) begin
                if (w_accept && (r_wr_sel == 1'(b))) begin
                    if (r_cnt == '0) begin
                        r_data[b] <= '0;
                        r_keep[b] <= '0;
                        r_last[b] <= 1'b0;
                    end
                    r_data[b][{r_cnt, 3'b000} +: 8] <= w_byte;
                    r_keep[b][r_cnt]                <= 1'b1;
                    if (w_close) begin
                        r_state[b] <= FULL;
                        r_last[b]  <= in_last;
                    end else begin
                        r_state[b] <= FILLING;
                    end
                end else if (w_drain && (r_rd_sel == 1'(b))) begin
                    r_state[b] <= EMPTY;
                end
            end

            if (w_accept) begin
                if (w_close) begin
                    r_wr_sel <= ~r_wr_sel;
                    r_cnt    <= '0;
                end else begin
                    r_cnt    <= r_cnt + CW'(1);
                end
            end

            if (w_drain) begin
                r_rd_sel <= ~r_rd_sel;
            end
        end
    end

    assign w_rd_data = r_data[r_rd_sel];
    assign w_rd_keep = r_keep[r_rd_sel];
    assign out_last  = r_last[r_rd_sel];

`ifdef BYTE_LANE_SWAP_EN
    assign out_data = {<<8{w_rd_data}};
    assign out_keep = {<<{w_rd_keep}};
`else
    assign out_data = w_rd_data;
    assign out_keep = w_rd_keep;
`endif

endmodule

// File: tb/tb_byte_lane_packer.sv
// Directed self-checking bench for byte_lane_packer with LANES=4.
module tb_byte_lane_packer;

    localparam int unsigned L = 4;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } word_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_data = '0;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_data;
    logic [3:0]   out_keep;
    logic         out_last;

    int unsigned  total = 0;
    int unsigned  bad = 0;
    word_t        q[$];

    byte_lane_packer #(.LANES(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    // Collect every handshaken word away from the active edge
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            q.push_back('{d: out_data, k: out_keep, l: out_last});
        end
    end

    function automatic logic [31:0] xd(input logic [31:0] w);
`ifdef BYTE_LANE_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic logic [3:0] xk(input logic [3:0] k);
`ifdef BYTE_LANE_SWAP_EN
        return {k[0], k[1], k[2], k[3]};
`else
        return k;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Caller sits 1 time unit after a rising edge; returns at the same phase
    task automatic send(input logic [7:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        chk("send_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [31:0] d, input logic [3:0] k, input logic l);
        word_t w;
        word_t e;
        int unsigned t;
        t = 0;
        while (q.size() == 0 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        e = '{d: xd(d), k: xk(k), l: l};
        if (q.size() == 0) begin
            chk({tag, "_timeout"}, 64'd0, 64'd1);
        end else begin
            w = q.pop_front();
            chk(tag, 64'(w), 64'(e));
        end
    endtask

    initial begin
        int unsigned n_acc;
        int unsigned sent;
        int unsigned budget;
        logic        acc;
        logic        feed_done;

        // Reset state
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_keep", 64'(out_keep), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;

        // Full word, valid one cycle after the final byte
        out_ready = 1'b1;
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        chk("a_valid_early", 64'(out_valid), 64'd0);
        send(8'h44, 1'b0);
        chk("a_valid", 64'(out_valid), 64'd1);
        chk("a_data", 64'(out_data), 64'(xd(32'h44332211)));
        expect_word("a_word", 32'h44332211, 4'hF, 1'b0);

        // Partial words closed by in_last, then the next word restarts at lane 0
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b1);
        send(8'hCC, 1'b0);
        send(8'hDD, 1'b0);
        send(8'hEE, 1'b0);
        send(8'hFF, 1'b0);
        send(8'hA5, 1'b1);
        expect_word("b_partial", 32'h0000BBAA, 4'h3, 1'b1);
        expect_word("b_next", 32'hFFEEDDCC, 4'hF, 1'b0);
        expect_word("b_single", 32'h000000A5, 4'h1, 1'b1);

        // Backpressure: both buffers fill, then drain in order
        out_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h30 + 8'(n_acc);
            acc      = in_ready;
            @(posedge clk); #1;
            if (acc) begin
                n_acc++;
                if (n_acc == 8) chk("c_ready_after8", 64'(in_ready), 64'd0);
            end
        end
        chk("c_accepted", 64'(n_acc), 64'd8);
        chk("c_ready_full", 64'(in_ready), 64'd0);
        chk("c_out_data", 64'(out_data), 64'(xd(32'h33323130)));
        out_ready = 1'b1;
        chk("c_ready_nocomb", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk("c_ready_next", 64'(in_ready), 64'd1);
        send(8'h38, 1'b0);
        send(8'h39, 1'b0);
        send(8'h3A, 1'b0);
        send(8'h3B, 1'b0);
        expect_word("c_w0", 32'h33323130, 4'hF, 1'b0);
        expect_word("c_w1", 32'h37363534, 4'hF, 1'b0);
        expect_word("c_w2", 32'h3B3A3938, 4'hF, 1'b0);

        // Reset mid-word discards the partial word
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("d_in_ready", 64'(in_ready), 64'd1);
        chk("d_out_valid", 64'(out_valid), 64'd0);
        chk("d_out_data", 64'(out_data), 64'd0);
        chk("d_out_keep", 64'(out_keep), 64'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        chk("d_queue_empty", 64'(q.size()), 64'd0);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        expect_word("d_word", 32'h04030201, 4'hF, 1'b0);

        // Random backpressure over 256 bytes
        feed_done = 1'b0;
        fork
            begin
                sent   = 0;
                budget = 0;
                while (sent < 256 && budget < 5000) begin
                    in_valid = 1'b1;
                    in_data  = 8'(sent);
                    acc      = in_ready;
                    @(posedge clk); #1;
                    budget++;
                    if (acc) sent++;
                end
                in_valid  = 1'b0;
                feed_done = 1'b1;
            end
            begin
                while (!feed_done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        join
        chk("e_all_sent", 64'(sent), 64'd256);
        out_ready = 1'b1;
        for (int w = 0; w < 64; w++) begin
            logic [7:0] b0;
            b0 = 8'(4 * w);
            expect_word("e_word", {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0}, 4'hF, 1'b0);
        end
        repeat (4) @(posedge clk);
        #1;
        chk("e_no_extra", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/byte_lane_packer.md
BYTE_LANE_PACKER -- requirements
Module: byte_lane_packer

Interface
REQ-001 SHALL have parameter LANES, default 4: bytes per output word, legal range 2..8.
REQ-002 SHALL have ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input byte offered.
- in_ready  output  1  packer accepts input byte.
- in_data  input  8  input byte.
- in_last  input  1  byte closes the current word, which may be partial.
- out_valid  output  1  packed word offered.
- out_ready  input  1  consumer accepts the packed word.
- out_data  output  LANES*8  packed word.
- out_keep  output  LANES  per-lane valid mask.
- out_last  output  1  word was closed by in_last.

Function
REQ-003 SHALL hold two word buffers as a packed array data[1:0][LANES*8-1:0], each with its own keep, last and state register.
REQ-004 Each buffer SHALL have state EMPTY, FILLING or FULL.
REQ-005 The write pointer wr_sel (1 bit) and the byte counter cnt (clog2(LANES) bits) SHALL select the target lane through an indexed part-select: data[wr_sel][cnt*8 +: 8].
REQ-006 in_ready SHALL equal (state[wr_sel] != FULL), combinationally.
REQ-007 On an accepted byte with cnt==0, the buffer SHALL be zeroed and lane 0 written, keep set to 1, and the state set to FILLING, all in the same cycle.
REQ-008 On an accepted byte with cnt>0, the byte SHALL be written to lane cnt and keep[cnt] set; other lanes SHALL be unchanged.
REQ-009 When an accepted byte has cnt==LANES-1 or in_last==1, the buffer SHALL become FULL, last SHALL get in_last, wr_sel SHALL toggle and cnt SHALL return to 0; otherwise cnt SHALL increment.
REQ-010 out_valid SHALL equal (state[rd_sel]==FULL). out_data, out_keep and out_last SHALL come from buffer rd_sel and SHALL be stable while out_valid && !out_ready.
REQ-011 On out_valid && out_ready, buffer rd_sel SHALL become EMPTY and rd_sel SHALL toggle.
REQ-012 Latency: the byte completing a word accepted on edge N SHALL give out_valid=1 after edge N, i.e. in cycle N+1.
REQ-013 Simultaneous write to one buffer and drain of the other SHALL both take effect in the same cycle.
REQ-014 Sustained throughput SHALL be one byte per cycle while out_ready is held high.
REQ-015 Both buffers FULL: in_ready SHALL be 0 and no state SHALL change until a drain.
REQ-016 A drain in that cycle SHALL NOT raise in_ready combinationally; in_ready SHALL rise the next cycle.
REQ-017 in_last with cnt==0 SHALL produce a single-lane word with keep=1.
REQ-018 in_data SHALL be ignored when in_valid==0 or in_ready==0.

Reset
REQ-019 Asserting rst at any time SHALL asynchronously clear both buffers to EMPTY, set data, keep and last to 0, and set wr_sel, rd_sel and cnt to 0.
REQ-020 Outputs during reset SHALL be: in_ready=1, out_valid=0, out_data=0, out_keep=0, out_last=0.
REQ-021 A partially filled word at reset SHALL be discarded.

Configuration
REQ-022 With macro BYTE_LANE_SWAP_EN defined, out_data SHALL be byte-reversed using a streaming operator {<<8{...}} and out_keep bit-reversed, so that lane 0 appears in the MSB byte.
REQ-023 Without BYTE_LANE_SWAP_EN, lane 0 SHALL appear at out_data[7:0] and out_keep[0]. The internal storage SHALL be identical in both builds.

Structure
REQ-024 Package byte_lane_pkg SHALL hold typedef lane_t (logic [7:0]), enum buf_state_e {EMPTY, FILLING, FULL}, and constant MAX_LANES=8.
REQ-025 The design SHALL be a single module with no sub-module; the two buffers SHALL be handled in one always_ff using per-buffer loops, not a separate instance.

Verification
REQ-026 LANES=4, bytes 11,22,33,44 on consecutive cycles, out_ready=1 -> out_data=44332211, keep=F, last=0, valid one cycle after byte 44.
REQ-027 Bytes AA,BB with in_last on BB -> out_data=0000BBAA, keep=3, last=1. The next word SHALL start at lane 0.
REQ-028 out_ready=0 while 12 bytes are offered -> exactly 8 accepted, in_ready=0 from the cycle after the 8th byte. Raising out_ready SHALL drain 2 words in order, then resume input.
REQ-029 rst pulsed mid-word after 2 bytes, then 4 new bytes 01..04 -> the only word out is 04030201. No stale lanes SHALL appear.
REQ-030 BYTE_LANE_SWAP_EN defined, bytes 11,22,33,44 -> out_data=11223344, keep=F. Partial word AA with last -> out_data=AA000000, keep=8.
REQ-031 out_ready toggling randomly over 256 bytes -> every byte SHALL be output exactly once, in order.
